// File: rtl/note_lut_pkg.sv
// Shared constants for the MIDI note -> oscillator divider lookup.
// Base dividers are round(1e6/f) for octave 5 (notes 60..71), 1 MHz reference.
package note_lut_pkg;

    localparam int          NOTE_W           = 7;
    localparam int          NOTES_PER_OCTAVE = 12;
    localparam int          BASE_OCTAVE      = 5;
    localparam logic [15:0] D_W_MAX          = 16'hFFFF;

    localparam logic [11:0] BASE_DIV [NOTES_PER_OCTAVE] = '{
        12'd3822, 12'd3608, 12'd3405, 12'd3214, 12'd3034, 12'd2863,
        12'd2703, 12'd2551, 12'd2408, 12'd2273, 12'd2145, 12'd2025
    };

    // Semitones 12..15 cannot come out of the octave split; return 0 defensively.
    function automatic logic [11:0] base_div(input logic [3:0] semi);
        logic [11:0] b;
        b = '0;
        if (semi < 4'(NOTES_PER_OCTAVE)) begin
            b = BASE_DIV[semi];
        end
        return b;
    endfunction

endpackage

// File: rtl/note_octave_split.sv
// Combinational split of a note number into octave (n/12) and semitone (n mod 12).
// Zero latency; restoring subtract chain over 96/48/24/12.
module note_octave_split (
    input  logic [6:0] note,
    output logic [3:0] octave,
    output logic [3:0] semitone
);

    logic [6:0] rem;

    always_comb begin
        rem    = note;
        octave = '0;
        if (rem >= 7'd96) begin
            rem       = rem - 7'd96;
            octave[3] = 1'b1;
        end
        if (rem >= 7'd48) begin
            rem       = rem - 7'd48;
            octave[2] = 1'b1;
        end
        if (rem >= 7'd24) begin
            rem       = rem - 7'd24;
            octave[1] = 1'b1;
        end
        if (rem >= 7'd12) begin
            rem       = rem - 7'd12;
            octave[0] = 1'b1;
        end
        semitone = rem[3:0];
    end

endmodule

// File: rtl/note_lut.sv
// Note-number to 16-bit oscillator divider lookup with one registered read port.
// Latency one bram_clk edge; bram_ce=0 holds the output, async reset clears it.
module note_lut #(
    parameter int ADDR_W      = 7,
    parameter int D_W         = 16,
    parameter int BASE_OCTAVE = note_lut_pkg::BASE_OCTAVE
) (
    input  logic              bram_clk,
    input  logic              bram_rst_n,
    input  logic              bram_ce,
    input  logic [ADDR_W-1:0] bram_addr,
    output logic [D_W-1:0]    bram_out
);

    import note_lut_pkg::*;

    logic [3:0]     octave;
    logic [3:0]     semitone;
    logic [11:0]    base;
    logic [21:0]    wide;
    logic [15:0]    div;
    logic [D_W-1:0] bram_out_d;
    logic [D_W-1:0] bram_out_q;

    // Only the low 7 address bits select a note; wider parent buses alias.
    note_octave_split u_split (
        .note     (bram_addr[NOTE_W-1:0]),
        .octave   (octave),
        .semitone (semitone)
    );

    always_comb begin
        base = base_div(semitone);
        wide = '0;
        if (octave < 4'(BASE_OCTAVE)) begin
            wide = {10'd0, base} << (4'(BASE_OCTAVE) - octave);
        end else begin
            wide = {10'd0, base} >> (octave - 4'(BASE_OCTAVE));
        end
        // Low octaves overflow 16 bits; clamp rather than wrap to keep the pitch monotonic.
        div = (|wide[21:16]) ? D_W_MAX : wide[15:0];
        bram_out_d = bram_ce ? D_W'(div) : bram_out_q;
    end

    always_ff @(posedge bram_clk or negedge bram_rst_n) begin
        if (!bram_rst_n) begin
            bram_out_q <= '0;
        end else begin
            bram_out_q <= bram_out_d;
        end
    end

    assign bram_out = bram_out_q;

endmodule

// File: tb/tb_note_lut.sv
// Scoreboard bench for note_lut: driver pushes expected outputs, monitor checks after each edge.
module tb_note_lut;

    logic        bram_clk;
    logic        bram_rst_n;
    logic        bram_ce;
    logic [6:0]  bram_addr;
    logic [15:0] bram_out;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [15:0] model;

    int base_tbl[12] = '{3822, 3608, 3405, 3214, 3034, 2863,
                         2703, 2551, 2408, 2273, 2145, 2025};

    note_lut u_dut (
        .bram_clk   (bram_clk),
        .bram_rst_n (bram_rst_n),
        .bram_ce    (bram_ce),
        .bram_addr  (bram_addr),
        .bram_out   (bram_out)
    );

    initial bram_clk = 1'b0;
    always #5 bram_clk = ~bram_clk;

    function automatic int ref_div(input int n);
        longint v;
        int     o;
        int     s;
        o = n / 12;
        s = n % 12;
        if (o < 5) v = longint'(base_tbl[s]) << (5 - o);
        else       v = longint'(base_tbl[s]) >> (o - 5);
        if (v > 65535) v = 65535;
        return int'(v);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One driven cycle: inputs change on the falling edge, expected value queued for the next rise.
    task automatic cyc(input logic rst, input logic ce, input int a, input int e);
        @(negedge bram_clk);
        bram_rst_n = rst;
        bram_ce    = ce;
        bram_addr  = 7'(a);
        if (!rst)    model = 16'd0;
        else if (ce) model = 16'(e);
        exp_q.push_back(model);
    endtask

    // Monitor: sample 1 ns after each rising edge and compare against the scoreboard head.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge bram_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", bram_out, e);
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        model      = 16'd0;
        bram_rst_n = 1'b0;
        bram_ce    = 1'b1;
        bram_addr  = 7'd69;
        #1;
        check("reset_immediate", bram_out, 16'd0);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 69, 0);
        cyc(1'b1, 1'b1, 69, 2273);

        // Octave scaling on semitone 9
        cyc(1'b1, 1'b1, 57, 4546);
        cyc(1'b1, 1'b1, 45, 9092);
        cyc(1'b1, 1'b1, 81, 1136);
        cyc(1'b1, 1'b1, 93, 568);

        // Extremes and saturation
        cyc(1'b1, 1'b1, 0, 65535);
        cyc(1'b1, 1'b1, 10, 65535);
        cyc(1'b1, 1'b1, 11, 64800);
        cyc(1'b1, 1'b1, 127, 79);
        cyc(1'b1, 1'b1, 60, 3822);

        // Enable gating
        cyc(1'b1, 1'b1, 60, 3822);
        cyc(1'b1, 1'b0, 72, 0);
        cyc(1'b1, 1'b0, 72, 0);
        cyc(1'b1, 1'b1, 72, 1911);

        // Base octave streaming
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 60 + i, base_tbl[i]);

        // Exhaustive sweep with an async reset pulse between edges near note 40
        for (int n = 0; n < 128; n++) begin
            if (n == 40) begin
                @(negedge bram_clk);
                bram_ce   = 1'b1;
                bram_addr = 7'd40;
                #2;
                bram_rst_n = 1'b0;
                #1;
                check("async_reset", bram_out, 16'd0);
                model = 16'd0;
                exp_q.push_back(model);
            end
            cyc(1'b1, 1'b1, n, ref_div(n));
        end

        cyc(1'b1, 1'b0, 5, 0);
        @(negedge bram_clk);
        @(negedge bram_clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
